// File: rtl/load_source_arbiter.sv
// Grants one of two ROM byte sources per download session, buffers its bytes
// in a small FIFO and emits them to the game loader with minimum strobe spacing.
module load_source_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP        = 4,
  parameter int TIMEOUT    = 1048576,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_downloading,
  input  logic [7:0]       req0_data,
  input  logic             req0_strobe,
  output logic             req0_ready,
  input  logic             req1_downloading,
  input  logic [7:0]       req1_data,
  input  logic             req1_strobe,
  output logic             req1_ready,
  output logic [1:0]       grant,
  output logic             downloading,
  output logic [7:0]       odata,
  output logic             odata_clk,
  output logic [CNT_W-1:0] byte_count,
  output logic             overflow,
  output logic             timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   READY_MAX = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_STREAM, S_DRAIN, S_FINISH} state_t;

  state_t          state, state_next;
  logic            gsel;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   idle_cnt;

  logic            sel_dl, sel_strobe;
  logic [7:0]      sel_data;
  logic            streaming, emitting, active, full;
  logic            push_req, push, pop, drop, timeout_hit;

  always_comb begin
    sel_dl      = gsel ? req1_downloading : req0_downloading;
    sel_strobe  = gsel ? req1_strobe      : req0_strobe;
    sel_data    = gsel ? req1_data        : req0_data;
    streaming   = (state == S_STREAM);
    emitting    = (state == S_STREAM) || (state == S_DRAIN);
    active      = emitting || (state == S_ARM);
    full        = (count == DEPTH_C);
    push_req    = streaming && sel_strobe;
    timeout_hit = streaming && !push_req && (idle_cnt == IDLE_LAST);
    // An abort flushes silently, so no pop is allowed on that edge.
    pop         = emitting && (count != '0) && (gap_cnt == '0) && !timeout_hit;
    push        = push_req && (!full || pop);
    drop        = push_req && full && !pop;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req1_downloading || req0_downloading) state_next = S_ARM;
      S_ARM:    state_next = S_STREAM;
      S_STREAM: begin
        if (timeout_hit)  state_next = S_FINISH;
        else if (!sel_dl) state_next = S_DRAIN;
      end
      S_DRAIN:  if ((count == '0) && !odata_clk) state_next = S_FINISH;
      // Holding here until the old source lets go avoids re-granting a stale session.
      S_FINISH: if (!sel_dl) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant       = active ? (gsel ? 2'b10 : 2'b01) : 2'b00;
    downloading = active;
    req0_ready  = streaming && !gsel && (count <= READY_MAX);
    req1_ready  = streaming &&  gsel && (count <= READY_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      gsel       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gap_cnt    <= '0;
      idle_cnt   <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      odata_clk  <= 1'b0;
      odata      <= '0;
    end else begin
      state     <= state_next;
      odata_clk <= pop;
      if (state == S_IDLE) gsel <= req1_downloading;

      if ((state == S_ARM) || timeout_hit) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      if (state == S_ARM)     gap_cnt <= '0;
      else if (pop)           gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      if ((state == S_ARM) || push) idle_cnt <= '0;
      else if (streaming)           idle_cnt <= idle_cnt + 1'b1;

      if (state == S_ARM) begin
        byte_count <= '0;
        overflow   <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        if (pop)         byte_count <= byte_count + 1'b1;
        if (drop)        overflow   <= 1'b1;
        if (timeout_hit) timeout    <= 1'b1;
      end

      if (pop) odata <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel_data;
  end

endmodule

// File: tb/tb_load_source_arbiter.sv
// Directed bench for load_source_arbiter: arbitration, pacing, overflow,
// idle timeout, reset mid-drain and the stale-session hold.
module tb_load_source_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_downloading, req0_strobe, req0_ready;
  logic [7:0]  req0_data;
  logic        req1_downloading, req1_strobe, req1_ready;
  logic [7:0]  req1_data;
  logic [1:0]  grant;
  logic        downloading;
  logic [7:0]  odata;
  logic        odata_clk;
  logic [15:0] byte_count;
  logic        overflow, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] pd [$];
  int         pc [$];

  load_source_arbiter #(.FIFO_DEPTH(8), .GAP(4), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_downloading(req0_downloading), .req0_data(req0_data),
    .req0_strobe(req0_strobe), .req0_ready(req0_ready),
    .req1_downloading(req1_downloading), .req1_data(req1_data),
    .req1_strobe(req1_strobe), .req1_ready(req1_ready),
    .grant(grant), .downloading(downloading), .odata(odata), .odata_clk(odata_clk),
    .byte_count(byte_count), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (odata_clk === 1'b1) begin
    pd.push_back(odata);
    pc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pdat(input int i);
    return (i < pd.size()) ? pd[i] : 8'hxx;
  endfunction

  function automatic int pcyc(input int i);
    return (i < pc.size()) ? pc[i] : -1000;
  endfunction

  task automatic wait_idle(input int bound, output int fall);
    int n = 0;
    while (downloading && n < bound) begin
      tick();
      n++;
    end
    fall = cyc;
    check("wait_downloading_low", {31'b0, downloading}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, {30'b0, grant}, 32'd0);
    check({tag, "_downloading"}, {31'b0, downloading}, 32'd0);
    check({tag, "_odata"}, {24'b0, odata}, 32'd0);
    check({tag, "_odata_clk"}, {31'b0, odata_clk}, 32'd0);
    check({tag, "_byte_count"}, {16'b0, byte_count}, 32'd0);
    check({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
    check({tag, "_timeout"}, {31'b0, timeout}, 32'd0);
    check({tag, "_ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
  endtask

  initial begin
    int fall, s0, last, n;
    logic [7:0] exp3 [14];
    exp3 = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
             8'h88, 8'h89, 8'h8A, 8'h8D, 8'h91, 8'h95};
    reset = 1'b1;
    req0_downloading = 0; req0_strobe = 0; req0_data = 0;
    req1_downloading = 0; req1_strobe = 0; req1_data = 0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Source 0 streams 0x00..0x0F, one strobe every 4 cycles.
    req0_downloading = 1;
    tick();
    check("t1_arm_grant", {30'b0, grant}, 32'h1);
    check("t1_arm_downloading", {31'b0, downloading}, 32'd1);
    tick();
    check("t1_ready", {30'b0, req1_ready, req0_ready}, 32'h1);
    pd.delete(); pc.delete();
    for (int i = 0; i < 16; i++) begin
      req0_data = 8'(i); req0_strobe = 1;
      tick();
      req0_strobe = 0;
      if (i == 0) s0 = cyc;
      repeat (3) tick();
    end
    req0_downloading = 0;
    wait_idle(40, fall);
    check("t1_pulses", pd.size(), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("t1_byte%0d", i), {24'b0, pdat(i)}, i);
    check("t1_latency", pcyc(0), s0 + 1);
    check("t1_byte_count", {16'b0, byte_count}, 32'd16);
    check("t1_flags", {30'b0, overflow, timeout}, 32'd0);
    check("t1_fall_after_last", {31'b0, fall > pcyc(15)}, 32'd1);
    tick(); tick();

    // Simultaneous requests: source 1 wins, source 0 strobes ignored.
    req0_downloading = 1; req1_downloading = 1;
    tick();
    check("t2_grant", {30'b0, grant}, 32'h2);
    tick();
    check("t2_ready", {30'b0, req1_ready, req0_ready}, 32'h2);
    pd.delete(); pc.delete();
    req0_data = 8'hAA; req0_strobe = 1; tick(); req0_strobe = 0;
    req1_data = 8'h51; req1_strobe = 1; tick(); req1_strobe = 0;
    tick(); tick();
    req0_data = 8'hBB; req0_strobe = 1; req1_data = 8'h52; req1_strobe = 1;
    tick();
    req0_strobe = 0; req1_strobe = 0;
    tick(); tick();
    req0_downloading = 0; req1_downloading = 0;
    wait_idle(40, fall);
    check("t2_pulses", pd.size(), 32'd2);
    check("t2_byte0", {24'b0, pdat(0)}, 32'h51);
    check("t2_byte1", {24'b0, pdat(1)}, 32'h52);
    check("t2_byte_count", {16'b0, byte_count}, 32'd2);
    tick(); tick();

    // Source 1 strobes every cycle for 24 bytes, ignoring ready.
    req1_downloading = 1;
    tick(); tick();
    pd.delete(); pc.delete();
    for (int i = 0; i < 24; i++) begin
      req1_data = 8'(8'h80 + i); req1_strobe = 1;
      tick();
    end
    req1_strobe = 0; req1_downloading = 0;
    wait_idle(200, fall);
    check("t3_overflow", {31'b0, overflow}, 32'd1);
    check("t3_pulses", pd.size(), 32'd14);
    for (int i = 0; i < 14; i++) check($sformatf("t3_byte%0d", i), {24'b0, pdat(i)}, {24'b0, exp3[i]});
    for (int i = 1; i < 14; i++) check($sformatf("t3_spacing%0d", i), pcyc(i) - pcyc(i-1), 32'd4);
    check("t3_byte_count", {16'b0, byte_count}, 32'd14);
    tick(); tick(); tick();
    check("t3_overflow_sticky_idle", {31'b0, overflow}, 32'd1);

    // Three bytes, then source 0 goes quiet with downloading held high.
    req0_downloading = 1;
    tick(); tick();
    check("t4_flags_cleared", {30'b0, overflow, timeout}, 32'd0);
    pd.delete(); pc.delete();
    for (int i = 0; i < 3; i++) begin
      req0_data = 8'(8'h10 + i); req0_strobe = 1;
      tick();
      req0_strobe = 0;
      if (i == 2) last = cyc;
      tick();
    end
    n = 0;
    while (!timeout && n < 100) begin
      tick();
      n++;
    end
    check("t4_timeout", {31'b0, timeout}, 32'd1);
    check("t4_timeout_cycle", cyc, last + 64);
    check("t4_downloading", {31'b0, downloading}, 32'd0);
    repeat (20) tick();
    check("t4_pulses", pd.size(), 32'd3);
    check("t4_byte2", {24'b0, pdat(2)}, 32'h12);
    check("t4_no_regrant", {30'b0, grant}, 32'd0);
    req0_downloading = 0;
    tick(); tick();

    // Reset while draining five buffered bytes.
    req0_downloading = 1;
    tick(); tick();
    pd.delete(); pc.delete();
    for (int i = 0; i < 7; i++) begin
      req0_data = 8'(8'h20 + i); req0_strobe = 1;
      tick();
    end
    req0_strobe = 0; req0_downloading = 0;
    tick();
    check("t5_draining", {31'b0, downloading}, 32'd1);
    check("t5_pre_pulses", pd.size(), 32'd2);
    reset = 1;
    tick();
    check_all_zero("t5_reset");
    reset = 0;
    repeat (10) tick();
    check("t5_no_pulse_after_reset", pd.size(), 32'd2);
    req1_downloading = 1;
    tick(); tick();
    check("t5_new_byte_count", {16'b0, byte_count}, 32'd0);
    req1_data = 8'h3C; req1_strobe = 1;
    tick();
    req1_strobe = 0; req1_downloading = 0;
    wait_idle(40, fall);
    check("t5_new_pulses", pd.size(), 32'd3);
    check("t5_new_byte", {24'b0, pdat(2)}, 32'h3C);
    check("t5_new_count", {16'b0, byte_count}, 32'd1);
    tick(); tick();

    // Source 0 reasserts downloading before FINISH; pending req1 waits.
    req0_downloading = 1;
    tick(); tick();
    req0_downloading = 0;
    tick();
    req0_downloading = 1; req1_downloading = 1;
    tick();
    check("t6_finish_downloading", {31'b0, downloading}, 32'd0);
    repeat (5) tick();
    check("t6_hold_grant", {30'b0, grant}, 32'd0);
    check("t6_hold_downloading", {31'b0, downloading}, 32'd0);
    req0_downloading = 0;
    tick();
    check("t6_idle_grant", {30'b0, grant}, 32'd0);
    tick();
    check("t6_arm_grant", {30'b0, grant}, 32'h2);
    check("t6_arm_downloading", {31'b0, downloading}, 32'd1);
    req1_downloading = 0;
    wait_idle(40, fall);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
